// File: rtl/pio_arb_pkg.sv
// pio_arb_pkg: shared types and constants for the PIO access arbiter
package pio_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, ACK} state_t;
  localparam int ADDR_W_DEF = 2;
  localparam int DATA_W_DEF = 32;
  localparam int M0 = 0;
  localparam int M1 = 1;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way one-hot grant, pointer selects the favoured master on contention
module rr_arb2 #(
  parameter int RR_MODE = 1
) (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] grant
);
  always_comb grant = (req == 2'b11) ? ((RR_MODE != 0 && ptr) ? 2'b10 : 2'b01) : req;
endmodule

// File: rtl/pio_access_arbiter.sv
// pio_access_arbiter: serialises two Avalon-MM masters onto one zero-latency PIO register slave
module pio_access_arbiter
  import pio_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RR_MODE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] s_address,
  output logic              s_chipselect,
  output logic              s_write_n,
  output logic [DATA_W-1:0] s_writedata,
  input  logic [DATA_W-1:0] s_readdata
);
  state_t      state;
  logic        ptr;
  logic        win;
  logic        wr;
  logic [1:0]  req;
  logic [1:0]  grant;
  logic        sel_write;
  assign req = {m1_read | m1_write, m0_read | m0_write};
  // read+write together is treated as a write
  assign sel_write = grant[M1] ? m1_write : m0_write;
  rr_arb2 #(.RR_MODE(RR_MODE)) u_arb (.req(req), .ptr(ptr), .grant(grant));
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      ptr              <= 1'b0;
      win              <= 1'b0;
      wr               <= 1'b0;
      m0_waitrequest   <= 1'b1;
      m1_waitrequest   <= 1'b1;
      m0_readdatavalid <= 1'b0;
      m1_readdatavalid <= 1'b0;
      m0_readdata      <= '0;
      m1_readdata      <= '0;
      s_address        <= '0;
      s_chipselect     <= 1'b0;
      s_write_n        <= 1'b1;
      s_writedata      <= '0;
    end else begin
      case (state)
        IDLE: if (|req) begin
          win          <= grant[M1];
          wr           <= sel_write;
          s_address    <= grant[M1] ? m1_address : m0_address;
          s_writedata  <= grant[M1] ? m1_writedata : m0_writedata;
          s_chipselect <= 1'b1;
          s_write_n    <= ~sel_write;
          state        <= ISSUE;
        end
        ISSUE: begin
          s_chipselect <= 1'b0;
          s_write_n    <= 1'b1;
          if (!wr && !win) m0_readdata <= s_readdata;
          if (!wr && win) m1_readdata <= s_readdata;
          m0_readdatavalid <= !wr && !win;
          m1_readdatavalid <= !wr && win;
          m0_waitrequest   <= win;
          m1_waitrequest   <= !win;
          state            <= ACK;
        end
        ACK: begin
          m0_waitrequest   <= 1'b1;
          m1_waitrequest   <= 1'b1;
          m0_readdatavalid <= 1'b0;
          m1_readdatavalid <= 1'b0;
          if (RR_MODE != 0) ptr <= ~win;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pio_access_arbiter.sv
// tb_pio_access_arbiter: directed checks of a round-robin and a fixed-priority arbiter driven by the same masters
module tb_pio_access_arbiter;
  import pio_arb_pkg::*;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  m0_address, m1_address;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        a_m0_wr, a_m1_wr, a_m0_rdv, a_m1_rdv, a_cs, a_wn;
  logic [31:0] a_m0_rd, a_m1_rd, a_wd, a_srd;
  logic [1:0]  a_addr;
  logic        b_m0_wr, b_m1_wr, b_m0_rdv, b_m1_rdv, b_cs, b_wn;
  logic [31:0] b_m0_rd, b_m1_rd, b_wd, b_srd;
  logic [1:0]  b_addr;
  logic [31:0] mem_a [4] = '{default: 32'h0};
  logic [31:0] mem_b [4] = '{default: 32'h0};
  int          checks = 0;
  int          failures = 0;
  int          na, nb, b_m1_grants;
  logic [3:0]  ga, gb;
  always #5 clk = ~clk;
  pio_access_arbiter #(.ADDR_W(2), .DATA_W(32), .RR_MODE(1)) dut_a (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
    .m0_waitrequest(a_m0_wr), .m0_readdata(a_m0_rd), .m0_readdatavalid(a_m0_rdv),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
    .m1_waitrequest(a_m1_wr), .m1_readdata(a_m1_rd), .m1_readdatavalid(a_m1_rdv),
    .s_address(a_addr), .s_chipselect(a_cs), .s_write_n(a_wn), .s_writedata(a_wd), .s_readdata(a_srd)
  );
  pio_access_arbiter #(.ADDR_W(2), .DATA_W(32), .RR_MODE(0)) dut_b (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write), .m0_writedata(m0_writedata),
    .m0_waitrequest(b_m0_wr), .m0_readdata(b_m0_rd), .m0_readdatavalid(b_m0_rdv),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write), .m1_writedata(m1_writedata),
    .m1_waitrequest(b_m1_wr), .m1_readdata(b_m1_rd), .m1_readdatavalid(b_m1_rdv),
    .s_address(b_addr), .s_chipselect(b_cs), .s_write_n(b_wn), .s_writedata(b_wd), .s_readdata(b_srd)
  );
  // zero-latency register slaves
  always @(posedge clk) if (a_cs && !a_wn) mem_a[a_addr] <= a_wd;
  always @(posedge clk) if (b_cs && !b_wn) mem_b[b_addr] <= b_wd;
  assign a_srd = mem_a[a_addr];
  assign b_srd = mem_b[b_addr];
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    {m0_address, m1_address, m0_read, m0_write, m1_read, m1_write} = '0;
    m0_writedata = '0;
    m1_writedata = '0;
    repeat (3) tick();
    reset = 1'b0;
    repeat (5) tick();
    chk("rst_m0_wait", 32'(a_m0_wr), 32'd1);
    chk("rst_m1_wait", 32'(a_m1_wr), 32'd1);
    chk("rst_cs_wn", {30'd0, a_cs, a_wn}, 32'b01);
    chk("rst_addr", 32'(a_addr), 32'd0);
    chk("rst_wdata", a_wd, 32'd0);
    chk("rst_rdv", {30'd0, a_m0_rdv, a_m1_rdv}, 32'd0);
    chk("rst_rdata", a_m0_rd | a_m1_rd, 32'd0);
    chk("rst_b_wait", {30'd0, b_m0_wr, b_m1_wr}, 32'b11);
    m0_address = 2'd0; m0_writedata = 32'h1; m0_write = 1'b1;
    tick();
    chk("wr_issue_cs_wn", {30'd0, a_cs, a_wn}, 32'b10);
    chk("wr_issue_wait", 32'(a_m0_wr), 32'd1);
    tick();
    chk("wr_ack_wait", 32'(a_m0_wr), 32'd0);
    chk("wr_ack_rdv", 32'(a_m0_rdv), 32'd0);
    chk("wr_ack_m1_wait", 32'(a_m1_wr), 32'd1);
    chk("wr_mem", mem_a[0], 32'h1);
    m0_write = 1'b0;
    tick();
    chk("wr_after_wait", 32'(a_m0_wr), 32'd1);
    m0_writedata = 32'hA5; m0_write = 1'b1;
    tick();
    tick();
    m0_write = 1'b0;
    tick();
    chk("wr_a5_mem", mem_a[0], 32'hA5);
    m1_address = 2'd0; m1_read = 1'b1;
    tick();
    chk("rd_issue_cs_wn", {30'd0, a_cs, a_wn}, 32'b11);
    tick();
    chk("rd_ack_rdv", 32'(a_m1_rdv), 32'd1);
    chk("rd_ack_data", a_m1_rd, 32'hA5);
    chk("rd_ack_wait", 32'(a_m1_wr), 32'd0);
    chk("rd_m0_quiet", {a_m0_rd[29:0], a_m0_rdv, a_m0_wr}, 32'b01);
    m1_read = 1'b0;
    tick();
    chk("rd_rdv_end", 32'(a_m1_rdv), 32'd0);
    chk("rd_data_hold", a_m1_rd, 32'hA5);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    m0_address = 2'd1; m0_writedata = 32'h10; m0_write = 1'b1;
    m1_address = 2'd2; m1_writedata = 32'h20; m1_write = 1'b1;
    na = 0; nb = 0; ga = '0; gb = '0; b_m1_grants = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (!a_m0_wr || !a_m1_wr) begin
        if (na < 4) ga[na] = !a_m1_wr;
        na++;
      end
      if (!b_m0_wr || !b_m1_wr) begin
        if (nb < 4) gb[nb] = !b_m1_wr;
        nb++;
      end
      if (!b_m1_wr) b_m1_grants++;
    end
    m0_write = 1'b0; m1_write = 1'b0;
    tick();
    chk("rr_count", 32'(na), 32'd4);
    chk("rr_order", 32'(ga), 32'b1010);
    chk("rr_mem_m0", mem_a[1], 32'h10);
    chk("rr_mem_m1", mem_a[2], 32'h20);
    chk("fp_count", 32'(nb), 32'd4);
    chk("fp_order", 32'(gb), 32'b0000);
    chk("fp_m1_grants", 32'(b_m1_grants), 32'd0);
    chk("fp_mem_m1", mem_b[2], 32'h0);
    chk("fp_mem_m0", mem_b[1], 32'h10);
    m1_address = 2'd0; m1_read = 1'b1;
    tick();
    chk("abort_state_issue", 32'(dut_a.state), 32'(ISSUE));
    reset = 1'b1;
    tick();
    chk("abort_rdv", 32'(a_m1_rdv), 32'd0);
    chk("abort_wait", 32'(a_m1_wr), 32'd1);
    chk("abort_state_idle", 32'(dut_a.state), 32'(IDLE));
    chk("abort_ptr", 32'(dut_a.ptr), 32'd0);
    chk("abort_cs", 32'(a_cs), 32'd0);
    reset = 1'b0;
    tick();
    chk("retry_rdv_early", 32'(a_m1_rdv), 32'd0);
    tick();
    chk("retry_rdv", 32'(a_m1_rdv), 32'd1);
    chk("retry_data", a_m1_rd, 32'hA5);
    chk("retry_b_data", {b_m1_rd[30:0], b_m1_rdv}, {31'hA5, 1'b1});
    m1_read = 1'b0;
    tick();
    chk("retry_done_wait", 32'(a_m1_wr), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
